p2s_serializer: RTL and testbench
=================================

Name: p2s_serializer

Overview:
- Parallel-to-serial converter; transmit-side counterpart of the team's serial-to-parallel deserializer.
- Accepts BUFFER_SIZE-bit words over a valid/ready handshake and emits them one bit per transfer, LSB first.
- Includes a one-word holding register so consecutive words stream with no idle cycle between them.
- Looping o_data/o_dv into the deserializer of equal BUFFER_SIZE reproduces each word exactly.

Parameters:
- BUFFER_SIZE, 4, word width in bits; must be >= 2.

Ports:
- i_clk  input  1  clock; all state on rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_data  input  BUFFER_SIZE  parallel word from source.
- i_dv  input  1  i_data valid.
- o_ready  output  1  block can accept a word this cycle.
- o_data  output  1  serial bit.
- o_dv  output  1  o_data valid.
- o_last  output  1  current bit is the word MSB (final bit).
- i_ready  input  1  serial sink accepts o_data this cycle.

Behaviour:
- Reset (async, asserted): shreg=0, cnt=0, pending_valid=0, state=IDLE. Outputs: o_dv=0, o_last=0, o_data=0, o_ready=0 while i_rst high, 1 after release.
- Reset mid-operation: the in-flight word and the pending word are discarded. No partial word is ever completed.
- Parallel accept: i_dv && o_ready at a rising edge. o_ready = !pending_valid && !i_rst (combinational from register).
- Serial transfer: o_dv && i_ready at a rising edge.
- State machine, IDLE/SHIFT:
  - o_dv = (state==SHIFT).
  - o_data = shreg[0].
  - o_last = o_dv && cnt==BUFFER_SIZE-1.
- Word routing on accept:
  - The word loads into shreg (cnt=0, state=SHIFT) if shreg is free at this edge: state IDLE, or a last-bit transfer with pending_valid=0.
  - Otherwise the word loads into the pending register and pending_valid=1.
- Non-last transfer: shreg shifts right with 0 entering at the MSB; cnt+1.
- Last-bit transfer:
  - If pending_valid: shreg loads pending, cnt=0, state stays SHIFT. pending_valid clears unless a simultaneous accept refills it.
  - Else, with a simultaneous accept: shreg loads i_data directly, no bubble.
  - Else: shreg shifts to all zeros and state goes to IDLE, so o_data=0 in IDLE.
- Latency: word accepted at edge N gives bit0 with o_dv=1 in the cycle after N.
- Throughput: 1 bit/cycle sustained when the source keeps pending full and i_ready=1.
- Backpressure: while i_ready=0 and o_dv=1, o_data, o_dv, o_last and cnt hold stable. Parallel accept into pending remains allowed.
- cnt width is $clog2(BUFFER_SIZE)+1. It wraps to 0 only via reload and never exceeds BUFFER_SIZE-1.
- i_data and i_dv are ignored when o_ready=0; the source must hold them until accepted.

Decomposition:
- Package p2s_pkg:
  - state_t enum {IDLE, SHIFT}.
  - function cnt_width(BUFFER_SIZE) returning $clog2(BUFFER_SIZE)+1.
- Single module; no sub-module. The pending register and the shift datapath are too small to split.

Test Plan:
1. Reset, send 4'b1011 with i_ready=1 → o_dv high for 4 consecutive cycles, o_data 1,1,0,1, o_last on the 4th bit only, o_ready stays 1.
2. Back-to-back 0xA, 0x5, 0xF with i_dv held high → 12 contiguous o_dv cycles with bits 0,1,0,1,1,0,1,0,1,1,1,1.
   - o_ready drops after the 0x5 accept.
   - o_ready reasserts the cycle after 0xA's last-bit transfer.
3. i_ready low for 3 cycles after bit1 of 0x6 → o_data=1 and o_dv=1 frozen, o_last=0. The sequence resumes 1,0 with no bit lost or duplicated.
4. Loopback into the deserializer (BUFFER_SIZE=4), 200 random words, random i_ready and i_dv gaps → deserializer outputs every word exactly once, in order.
5. Assert i_rst after 2 bits of 0x9 with pending=0x3 → o_dv/o_last fall immediately, o_ready=1 after release. The next word 0xC serializes from bit0 as 0,0,1,1 and 0x3 is never emitted.
6. Last bit of 0x1 transfers with pending empty while i_dv presents 0x8 → o_dv stays high with no bubble; next bits are 0,0,0,1.

Source files
------------

// File: rtl/p2s_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial converter.
package p2s_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit counter width: enough to hold 0..BUFFER_SIZE-1 with one spare bit.
    function automatic int unsigned cnt_width(input int unsigned buffer_size);
        return $clog2(buffer_size) + 1;
    endfunction

endpackage

// File: rtl/p2s_serializer.sv
// Parallel-to-serial converter: LSB-first bit stream with a one-word holding register.
module p2s_serializer
    import p2s_pkg::*;
#(
    parameter int unsigned BUFFER_SIZE = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [BUFFER_SIZE-1:0] i_data,
    input  logic                   i_dv,
    output logic                   o_ready,
    output logic                   o_data,
    output logic                   o_dv,
    output logic                   o_last,
    input  logic                   i_ready
);

    localparam int unsigned CNT_W = cnt_width(BUFFER_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUFFER_SIZE - 1);

    state_t                 state,         state_n;
    logic [BUFFER_SIZE-1:0] shreg,         shreg_n;
    logic [CNT_W-1:0]       cnt,           cnt_n;
    logic [BUFFER_SIZE-1:0] pending,       pending_n;
    logic                   pending_valid, pending_valid_n;

    logic accept;
    logic xfer;
    logic last_xfer;

    // Handshake qualifiers and serial outputs, all derived from registered state.
    always_comb begin
        o_ready   = !pending_valid && !i_rst;
        o_dv      = (state == SHIFT);
        o_data    = shreg[0];
        o_last    = o_dv && (cnt == CNT_LAST);
        accept    = i_dv && o_ready;
        xfer      = o_dv && i_ready;
        last_xfer = xfer && (cnt == CNT_LAST);
    end

    // State register; reset discards both the in-flight and pending word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            shreg         <= '0;
            cnt           <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
        end else begin
            state         <= state_n;
            shreg         <= shreg_n;
            cnt           <= cnt_n;
            pending       <= pending_n;
            pending_valid <= pending_valid_n;
        end
    end

    // Next-state: word routing between shift register and holding register.
    always_comb begin
        state_n         = state;
        shreg_n         = shreg;
        cnt_n           = cnt;
        pending_n       = pending;
        pending_valid_n = pending_valid;

        case (state)
            IDLE: begin
                if (accept) begin
                    shreg_n = i_data;
                    cnt_n   = '0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                if (last_xfer) begin
                    if (pending_valid) begin
                        shreg_n         = pending;
                        cnt_n           = '0;
                        pending_valid_n = 1'b0;
                        if (accept) begin
                            pending_n       = i_data;
                            pending_valid_n = 1'b1;
                        end
                    end else if (accept) begin
                        // Shift register frees up this edge, so skip the holding stage.
                        shreg_n = i_data;
                        cnt_n   = '0;
                    end else begin
                        shreg_n = '0;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        shreg_n = shreg >> 1;
                        cnt_n   = cnt + CNT_W'(1);
                    end
                    if (accept) begin
                        pending_n       = i_data;
                        pending_valid_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_p2s_serializer.sv
// Directed bench for p2s_serializer with a bit-collecting loopback model.
module tb_p2s_serializer;

    localparam int unsigned BS = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [BS-1:0] i_data;
    logic          i_dv;
    logic          o_ready;
    logic          o_data;
    logic          o_dv;
    logic          o_last;
    logic          i_ready;

    int n_tests = 0;
    int n_fail  = 0;

    p2s_serializer #(.BUFFER_SIZE(BS)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_data  (i_data),
        .i_dv    (i_dv),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_dv    (o_dv),
        .o_last  (o_last),
        .i_ready (i_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [11:0] exp_bits2;
    logic [11:0] exp_rdy2;
    logic [3:0]  exp_bits;
    logic [BS-1:0] words2 [3];
    logic [BS-1:0] q_sent [$];
    logic [BS-1:0] rx_word;
    logic [BS-1:0] exp_word;
    int            rx_cnt;
    int            rx_words;
    int            idx;
    int            cycles;
    logic          acc;
    logic          holding;

    initial begin
        rst = 1'b1; i_data = '0; i_dv = 1'b0; i_ready = 1'b1;
        #2;
        // Reset state
        check("rst_o_dv",    32'(o_dv),    32'd0);
        check("rst_o_last",  32'(o_last),  32'd0);
        check("rst_o_data",  32'(o_data),  32'd0);
        check("rst_o_ready", 32'(o_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rel_o_ready", 32'(o_ready), 32'd1);

        // Test 1: single word 1011
        i_dv = 1'b1; i_data = 4'b1011;
        tick();
        i_dv = 1'b0;
        exp_bits = 4'b1011;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_dv%0d", i),   32'(o_dv),    32'd1);
            check($sformatf("t1_bit%0d", i),  32'(o_data),  32'(exp_bits[i]));
            check($sformatf("t1_last%0d", i), 32'(o_last),  32'(i == 3));
            check($sformatf("t1_rdy%0d", i),  32'(o_ready), 32'd1);
            tick();
        end
        check("t1_idle_dv", 32'(o_dv), 32'd0);

        // Test 2: back-to-back A, 5, F with i_dv held
        words2[0] = 4'hA; words2[1] = 4'h5; words2[2] = 4'hF;
        exp_bits2 = 12'b1111_0101_1010; // bit k = k-th serial bit
        exp_rdy2  = 12'b1111_0001_0001; // bit k = expected o_ready in cycle k
        idx = 0;
        i_dv = 1'b1; i_data = words2[0];
        check("t2_rdy_pre", 32'(o_ready), 32'd1);
        tick();
        idx = 1;
        for (int k = 0; k < 12; k++) begin
            i_dv   = (idx < 3);
            i_data = (idx < 3) ? words2[idx] : '0;
            check($sformatf("t2_dv%0d", k),   32'(o_dv),    32'd1);
            check($sformatf("t2_bit%0d", k),  32'(o_data),  32'(exp_bits2[k]));
            check($sformatf("t2_last%0d", k), 32'(o_last),  32'((k % 4) == 3));
            check($sformatf("t2_rdy%0d", k),  32'(o_ready), 32'(exp_rdy2[k]));
            acc = i_dv && o_ready;
            tick();
            if (acc) idx++;
        end
        i_dv = 1'b0;
        check("t2_idle_dv", 32'(o_dv), 32'd0);
        check("t2_all_acc", 32'(idx),  32'd3);

        // Test 3: backpressure during 0x6
        i_dv = 1'b1; i_data = 4'h6;
        tick();
        i_dv = 1'b0;
        check("t3_bit0", 32'(o_data), 32'd0);
        tick();
        check("t3_bit1", 32'(o_data), 32'd1);
        tick();
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_hold_data%0d", i), 32'(o_data), 32'd1);
            check($sformatf("t3_hold_dv%0d", i),   32'(o_dv),   32'd1);
            check($sformatf("t3_hold_last%0d", i), 32'(o_last), 32'd0);
            tick();
        end
        i_ready = 1'b1;
        check("t3_bit2", 32'(o_data), 32'd1);
        check("t3_last2", 32'(o_last), 32'd0);
        tick();
        check("t3_bit3", 32'(o_data), 32'd0);
        check("t3_last3", 32'(o_last), 32'd1);
        tick();
        check("t3_idle_dv", 32'(o_dv), 32'd0);

        // Test 5: reset mid-word with a pending word
        i_dv = 1'b1; i_data = 4'h9;
        tick();
        i_data = 4'h3;                   // accepted into pending this cycle
        check("t5_bit0", 32'(o_data), 32'd1);
        tick();
        i_dv = 1'b0;
        check("t5_rdy_full", 32'(o_ready), 32'd0);
        check("t5_bit1", 32'(o_data), 32'd0);
        tick();
        rst = 1'b1;
        #1;
        check("t5_rst_dv",   32'(o_dv),    32'd0);
        check("t5_rst_last", 32'(o_last),  32'd0);
        check("t5_rst_rdy",  32'(o_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("t5_rel_rdy", 32'(o_ready), 32'd1);
        check("t5_rel_dv",  32'(o_dv),    32'd0);
        i_dv = 1'b1; i_data = 4'hC;
        tick();
        i_dv = 1'b0;
        exp_bits = 4'hC;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_c_dv%0d", i),  32'(o_dv),   32'd1);
            check($sformatf("t5_c_bit%0d", i), 32'(o_data), 32'(exp_bits[i]));
            tick();
        end
        check("t5_no_pending", 32'(o_dv), 32'd0);

        // Test 6: direct reload on last bit with pending empty
        i_dv = 1'b1; i_data = 4'h1;
        tick();
        i_dv = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("t6_last1", 32'(o_last), 32'd1);
        check("t6_rdy",   32'(o_ready), 32'd1);
        i_dv = 1'b1; i_data = 4'h8;
        tick();
        i_dv = 1'b0;
        exp_bits = 4'h8;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6_dv%0d", i),  32'(o_dv),   32'd1);
            check($sformatf("t6_bit%0d", i), 32'(o_data), 32'(exp_bits[i]));
            tick();
        end
        check("t6_idle_dv", 32'(o_dv), 32'd0);

        // Test 4: random loopback of 200 words with gaps on both sides
        rx_cnt = 0; rx_words = 0; idx = 0; cycles = 0; holding = 1'b0;
        rx_word = '0;
        while (rx_words < 200 && cycles < 20000) begin
            if (!holding && idx < 200 && ($urandom_range(0, 3) != 0)) begin
                holding = 1'b1;
                i_data  = BS'($urandom);
            end
            i_dv    = holding;
            i_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (o_dv && i_ready) begin
                rx_word[rx_cnt] = o_data;
                check("t4_last_pos", 32'(o_last), 32'(rx_cnt == BS - 1));
                if (rx_cnt == BS - 1) begin
                    if (q_sent.size() == 0) begin
                        check("t4_unexpected_word", 32'(rx_word), 32'hFFFF_FFFF);
                    end else begin
                        exp_word = q_sent.pop_front();
                        check("t4_word", 32'(rx_word), 32'(exp_word));
                    end
                    rx_cnt = 0;
                    rx_words++;
                end else begin
                    rx_cnt++;
                end
            end
            acc = i_dv && o_ready;
            if (acc) begin
                q_sent.push_back(i_data);
                holding = 1'b0;
                idx++;
            end
            tick();
            cycles++;
        end
        i_dv = 1'b0; i_ready = 1'b1;
        check("t4_words_rx", 32'(rx_words), 32'd200);
        check("t4_queue_empty", 32'(q_sent.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
